// File: rtl/mux_piso_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mux_piso_sequencer_pkg
// Shared definitions for the parallel-in/serial-out sequencer and its mux.
//   - WORD_W / SEL_W : word width and select width of the 8:1 mux
//   - state_t        : sequencer FSM state (idle / shifting a word)
//   - beat_sel()     : maps a beat index to the mux select for a bit order
// -----------------------------------------------------------------------------
package mux_piso_sequencer_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SEL_MAX = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Beat index -> mux select. LSB-first walks the word upward; MSB-first
    // mirrors the index. The subtraction stays in SEL_W bits and never wraps
    // because cnt never exceeds SEL_MAX.
    function automatic logic [SEL_W-1:0] beat_sel(input logic [SEL_W-1:0] cnt,
                                                  input bit               msb_first);
        return msb_first ? (SEL_MAX - cnt) : cnt;
    endfunction

endpackage

// File: rtl/mux_piso_sequencer_mux8x1.sv
// -----------------------------------------------------------------------------
// mux8x1
// Plain combinational 8:1 single-bit multiplexer.
//   din  [7:0] : data word
//   sel  [2:0] : bit index to forward
//   dout       : din[sel]
// -----------------------------------------------------------------------------
module mux8x1
    import mux_piso_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] din,
    input  logic [SEL_W-1:0]  sel,
    output logic              dout
);

    assign dout = din[sel];

endmodule

// File: rtl/mux_piso_sequencer.sv
// -----------------------------------------------------------------------------
// mux_piso_sequencer
// Accepts one 8-bit word over a valid/ready handshake and streams it out one
// bit per output handshake by stepping the select of an 8:1 mux.
//
// Parameters
//   MSB_FIRST  : 0 = bit 0 first (sel 0..7), 1 = bit 7 first (sel 7..0)
//   IDLE_LEVEL : level on out_bit while no word is in flight
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous reset, active high
//   in_valid  : upstream word available
//   in_ready  : word can be accepted this cycle
//   in_data   : parallel word, sampled on in_valid && in_ready
//   out_bit   : current serial bit
//   out_valid : out_bit is valid
//   out_ready : downstream takes out_bit this cycle
//   out_last  : current bit is the 8th of the word
//   busy      : a word is in flight
//   sel_dbg   : select currently driven into the mux
// -----------------------------------------------------------------------------
module mux_piso_sequencer
    import mux_piso_sequencer_pkg::*;
#(
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [SEL_W-1:0]  sel_dbg
);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  data_q,  data_d;
    logic [SEL_W-1:0]   cnt_q,   cnt_d;
    logic [SEL_W-1:0]   sel;
    logic               mux_out;
    logic               shifting;
    logic               last_beat;
    logic               beat;
    logic               accept;

    // -------------------------------------------------------------------------
    // Handshake qualifiers. in_ready opens during the last beat only when that
    // beat is actually taken, so a follow-on word loads with no bubble.
    // -------------------------------------------------------------------------
    assign shifting  = (state_q == ST_SHIFT);
    assign last_beat = shifting && (cnt_q == SEL_MAX);
    assign beat      = shifting && out_ready;
    assign in_ready  = (state_q == ST_IDLE) || (last_beat && out_ready);
    assign accept    = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold value first so no path through the
        // case leaves it unassigned; without this the block infers latches.
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (beat) begin
                    if (cnt_q != SEL_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (accept) begin
                        // Last bit leaves while the next word loads.
                        data_d = in_data;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            // NOTE: the data word is an ordinary register, not a memory, so it
            // is cleared too; the mux then never forwards an unknown bit.
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Bit selection and outputs (combinational from registers, no latency)
    // -------------------------------------------------------------------------
    assign sel = beat_sel(cnt_q, MSB_FIRST);

    mux8x1 u_mux (
        .din  (data_q),
        .sel  (sel),
        .dout (mux_out)
    );

    assign out_bit   = shifting ? mux_out : IDLE_LEVEL;
    assign out_valid = shifting;
    assign out_last  = last_beat;
    assign busy      = shifting;
    assign sel_dbg   = sel;

endmodule

// File: tb/tb_mux_piso_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_piso_sequencer
// Two sequencers share one stimulus stream: one LSB-first with idle level 0,
// one MSB-first with idle level 1. A queue-based reference model tracks the
// bit indices still owed to the downstream side and predicts every output.
// -----------------------------------------------------------------------------
module tb_mux_piso_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       l_in_ready, l_out_bit, l_out_valid, l_out_last, l_busy;
    logic [2:0] l_sel;
    logic       m_in_ready, m_out_bit, m_out_valid, m_out_last, m_busy;
    logic [2:0] m_sel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the word being sent plus the bit indices not yet taken.
    logic [7:0] ref_word;
    int         ref_ql[$];
    int         ref_qm[$];

    // Observation logs for the hand-written sequences.
    logic       obs[$];
    logic       rdy_log[$];
    int         shift_cycles;

    mux_piso_sequencer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .out_bit(l_out_bit), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .busy(l_busy),
        .sel_dbg(l_sel)
    );

    mux_piso_sequencer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .out_bit(m_out_bit), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_last(m_out_last), .busy(m_busy),
        .sel_dbg(m_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare both DUTs against the reference model for the current inputs.
    task automatic compare_model();
        int   sz;
        logic e_valid, e_ready;
        sz      = ref_ql.size();
        e_valid = (sz > 0);
        e_ready = (sz == 0) || (sz == 1 && out_ready);
        check("l_valid", 16'(l_out_valid), 16'(e_valid));
        check("l_busy",  16'(l_busy),      16'(e_valid));
        check("l_last",  16'(l_out_last),  16'(sz == 1));
        check("l_ready", 16'(l_in_ready),  16'(e_ready));
        check("l_bit",   16'(l_out_bit),   16'(e_valid ? ref_word[ref_ql[0]] : 1'b0));
        check("l_sel",   16'(l_sel),       16'(e_valid ? ref_ql[0] : 0));
        check("m_valid", 16'(m_out_valid), 16'(e_valid));
        check("m_last",  16'(m_out_last),  16'(sz == 1));
        check("m_ready", 16'(m_in_ready),  16'(e_ready));
        check("m_bit",   16'(m_out_bit),   16'(e_valid ? ref_word[ref_qm[0]] : 1'b1));
        check("m_sel",   16'(m_sel),       16'(e_valid ? ref_qm[0] : 7));
    endtask

    // Advance the reference model across one clock edge.
    task automatic update_model();
        logic beat_m, accept_m;
        int   sz;
        sz = ref_ql.size();
        if (rst) begin
            ref_ql.delete();
            ref_qm.delete();
            ref_word = '0;
        end else begin
            beat_m   = (sz > 0) && out_ready;
            accept_m = in_valid && ((sz == 0) || (sz == 1 && out_ready));
            if (beat_m) begin
                void'(ref_ql.pop_front());
                void'(ref_qm.pop_front());
            end
            if (accept_m) begin
                ref_word = in_data;
                for (int i = 0; i < 8; i++) begin
                    ref_ql.push_back(i);
                    ref_qm.push_back(7 - i);
                end
            end
        end
    endtask

    task automatic settle(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #3;
        compare_model();
        if (l_out_valid && out_ready) begin
            obs.push_back(l_out_bit);
            rdy_log.push_back(l_in_ready);
        end
        if (l_busy) shift_cycles++;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic cycle(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
        settle(r, iv, d, ordy);
        finish_cycle();
    endtask

    task automatic clear_logs();
        obs.delete();
        rdy_log.delete();
        shift_cycles = 0;
    endtask

    function automatic logic [15:0] pack_obs();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < obs.size() && i < 16; i++) v[i] = obs[i];
        return v;
    endfunction

    function automatic logic [15:0] pack_rdy();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < rdy_log.size() && i < 16; i++) v[i] = rdy_log[i];
        return v;
    endfunction

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_valid;
        logic       e_bit;
        logic       e_last;
        logic       e_ready;
        logic [2:0] e_sel;
        logic       e_mbit;
        logic [2:0] e_msel;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [7:0] w;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        ref_word = '0;
        clear_logs();

        // Reset held for two cycles, then idle outputs.
        repeat (2) @(posedge clk);
        #1;
        settle(1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_valid", 16'(l_out_valid), 16'd0);
        check("rst_busy",  16'(l_busy),      16'd0);
        check("rst_ready", 16'(l_in_ready),  16'd1);
        check("rst_bit",   16'(l_out_bit),   16'd0);
        check("rst_sel",   16'(l_sel),       16'd0);
        check("rst_mbit",  16'(m_out_bit),   16'd1);
        check("rst_msel",  16'(m_sel),       16'd7);
        finish_cycle();

        // Table: single word 8'hA5, accept then 8 beats then idle.
        w = 8'hA5;
        tbl[0] = '{1'b1, w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd7};
        for (int k = 1; k <= 8; k++) begin
            tbl[k] = '{1'b0, 8'h00, 1'b1, 1'b1, w[k-1], (k == 8), (k == 8),
                       3'(k - 1), w[8-k], 3'(8 - k)};
        end
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd7};

        for (int i = 0; i < 10; i++) begin
            settle(1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check($sformatf("tbl%0d_valid", i), 16'(l_out_valid), 16'(tbl[i].e_valid));
            check($sformatf("tbl%0d_bit", i),   16'(l_out_bit),   16'(tbl[i].e_bit));
            check($sformatf("tbl%0d_last", i),  16'(l_out_last),  16'(tbl[i].e_last));
            check($sformatf("tbl%0d_ready", i), 16'(l_in_ready),  16'(tbl[i].e_ready));
            check($sformatf("tbl%0d_sel", i),   16'(l_sel),       16'(tbl[i].e_sel));
            check($sformatf("tbl%0d_mbit", i),  16'(m_out_bit),   16'(tbl[i].e_mbit));
            check($sformatf("tbl%0d_msel", i),  16'(m_sel),       16'(tbl[i].e_msel));
            finish_cycle();
        end

        // Stall: 8'h3C, out_ready low for three cycles while beat 3 is shown.
        clear_logs();
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        begin
            logic ordy_pat[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 11; i++) begin
                settle(1'b0, 1'b0, 8'h00, ordy_pat[i]);
                if (!ordy_pat[i]) begin
                    check("stall_sel",   16'(l_sel),       16'd2);
                    check("stall_bit",   16'(l_out_bit),   16'd1);
                    check("stall_valid", 16'(l_out_valid), 16'd1);
                end
                finish_cycle();
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("stall_nbeats", 16'(obs.size()), 16'd8);
        check("stall_stream", pack_obs(),      16'h003C);
        check("stall_cycles", 16'(shift_cycles), 16'd11);

        // Back-to-back: 8'hFF then 8'h00, in_valid held high, junk data mid-word.
        clear_logs();
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, (i == 7) ? 8'h00 : 8'h5A, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("b2b_nbeats", 16'(obs.size()),   16'd16);
        check("b2b_stream", pack_obs(),        16'h00FF);
        check("b2b_ready",  pack_rdy(),        16'h8080);
        check("b2b_cycles", 16'(shift_cycles), 16'd16);

        // Reset mid-word: 8'h81 aborted at beat 4, then 8'h01.
        cycle(1'b0, 1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        clear_logs();
        settle(1'b0, 1'b0, 8'h00, 1'b1);
        check("abort_valid", 16'(l_out_valid), 16'd0);
        check("abort_busy",  16'(m_busy),      16'd0);
        finish_cycle();
        cycle(1'b0, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("abort_nbeats", 16'(obs.size()), 16'd8);
        check("abort_stream", pack_obs(),      16'h0001);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
